// File: rtl/time_pkg.sv
// Shared constants for the alarm-clock time-of-day counter.
package time_pkg;

    localparam int unsigned SEC_MAX       = 59;
    localparam int unsigned MIN_MAX       = 59;
    localparam int unsigned HOUR_MAX      = 23;
    localparam int unsigned HOUR_12       = 12;
    localparam int unsigned CNT_W_DEFAULT = 6;

endpackage

// File: rtl/time_counter_if.sv
// Control inputs and time/pulse outputs of the time-of-day counter.
interface time_counter_if
    import time_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
);

    logic             run;
    logic             mode_12h;
    logic             set_min;
    logic             set_hour;
    logic             load;
    logic [CNT_W-1:0] load_hours;
    logic [CNT_W-1:0] load_minutes;
    logic [CNT_W-1:0] load_seconds;

    logic [CNT_W-1:0] seconds;
    logic [CNT_W-1:0] minutes;
    logic [CNT_W-1:0] hours;
    logic [CNT_W-1:0] hours_disp;
    logic             pm;
    logic             sec_pulse;
    logic             min_pulse;
    logic             hour_pulse;
    logic             day_pulse;

    modport master (
        output run, mode_12h, set_min, set_hour, load,
        output load_hours, load_minutes, load_seconds,
        input  seconds, minutes, hours, hours_disp, pm,
        input  sec_pulse, min_pulse, hour_pulse, day_pulse
    );

    modport slave (
        input  run, mode_12h, set_min, set_hour, load,
        input  load_hours, load_minutes, load_seconds,
        output seconds, minutes, hours, hours_disp, pm,
        output sec_pulse, min_pulse, hour_pulse, day_pulse
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with increment, parallel load and range-checked load value.
module mod_counter #(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic at_max;

    assign at_max = (value == W'(MAX));
    assign wrap   = inc && at_max;

    // Out-of-range load values fall back to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= (load_val > W'(MAX)) ? '0 : load_val;
        end else if (inc) begin
            value <= at_max ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter: cycle prescaler, h/m/s fields, manual set/load, carry pulses, 12h display.
module time_counter
    import time_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC = 100_000_000,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    time_counter_if.slave  bus
);

    localparam int unsigned PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    logic [PRE_W-1:0] presc;
    logic             presc_term;
    logic             tick;

    logic [CNT_W-1:0] sec;
    logic [CNT_W-1:0] min;
    logic [CNT_W-1:0] hr;
    logic [CNT_W-1:0] disp;

    logic sec_wrap, min_wrap, hour_wrap;
    logic sec_carry, min_carry;
    logic min_inc, hour_inc;
    logic min_pulse_c, hour_pulse_c, day_pulse_c;

    assign presc_term = (presc == PRE_W'(CLK_PER_SEC - 1));
    assign tick       = bus.run && presc_term && !bus.load;

    always_ff @(posedge clk) begin
        if (reset || bus.load) begin
            presc <= '0;
        end else if (bus.run) begin
            presc <= presc_term ? '0 : presc + PRE_W'(1);
        end
    end

    // A manual set on a field swallows any carry arriving into it that cycle
    assign sec_carry = sec_wrap;
    assign min_inc   = bus.set_min || sec_carry;
    assign min_carry = min_wrap && !bus.set_min;
    assign hour_inc  = bus.set_hour || min_carry;

    assign min_pulse_c  = sec_carry && !bus.set_min;
    assign hour_pulse_c = min_carry && !bus.set_hour;
    assign day_pulse_c  = hour_wrap && min_carry && !bus.set_hour;

    mod_counter #(.MAX(SEC_MAX), .W(CNT_W)) u_sec (
        .clk      (clk),
        .reset    (reset),
        .inc      (tick),
        .load     (bus.load),
        .load_val (bus.load_seconds),
        .value    (sec),
        .wrap     (sec_wrap)
    );

    mod_counter #(.MAX(MIN_MAX), .W(CNT_W)) u_min (
        .clk      (clk),
        .reset    (reset),
        .inc      (min_inc),
        .load     (bus.load),
        .load_val (bus.load_minutes),
        .value    (min),
        .wrap     (min_wrap)
    );

    mod_counter #(.MAX(HOUR_MAX), .W(CNT_W)) u_hour (
        .clk      (clk),
        .reset    (reset),
        .inc      (hour_inc),
        .load     (bus.load),
        .load_val (bus.load_hours),
        .value    (hr),
        .wrap     (hour_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.sec_pulse  <= 1'b0;
            bus.min_pulse  <= 1'b0;
            bus.hour_pulse <= 1'b0;
            bus.day_pulse  <= 1'b0;
        end else begin
            bus.sec_pulse  <= tick;
            bus.min_pulse  <= min_pulse_c;
            bus.hour_pulse <= hour_pulse_c;
            bus.day_pulse  <= day_pulse_c;
        end
    end

    // 12h display: 0 shows as 12, 13..23 fold down by 12
    always_comb begin
        disp = hr;
        if (bus.mode_12h) begin
            if (hr == '0) begin
                disp = CNT_W'(HOUR_12);
            end else if (hr > CNT_W'(HOUR_12)) begin
                disp = hr - CNT_W'(HOUR_12);
            end
        end
    end

    assign bus.seconds    = sec;
    assign bus.minutes    = min;
    assign bus.hours      = hr;
    assign bus.hours_disp = disp;
    assign bus.pm         = (hr >= CNT_W'(HOUR_12));

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter with a 4-cycle second.
module tb_time_counter;

    localparam int unsigned CPS = 4;
    localparam int unsigned W   = 7;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    time_counter_if #(.CNT_W(W)) bus ();

    time_counter #(.CLK_PER_SEC(CPS), .CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_time(input int h, input int m, input int s);
        bus.load_hours   = W'(h);
        bus.load_minutes = W'(m);
        bus.load_seconds = W'(s);
        bus.load         = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".h"}, 32'(bus.hours), 32'(h));
        chk({tag, ".m"}, 32'(bus.minutes), 32'(m));
        chk({tag, ".s"}, 32'(bus.seconds), 32'(s));
    endtask

    function automatic logic [31:0] pulses();
        return {28'd0, bus.day_pulse, bus.hour_pulse, bus.min_pulse, bus.sec_pulse};
    endfunction

    int unsigned hr_tab[5]   = '{0, 1, 12, 13, 23};
    int unsigned disp_tab[5] = '{12, 1, 12, 1, 11};
    int unsigned pm_tab[5]   = '{0, 0, 1, 1, 1};

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.run = 1'b0;
        bus.mode_12h = 1'b0;
        bus.set_min = 1'b0;
        bus.set_hour = 1'b0;
        bus.load = 1'b0;
        bus.load_hours = '0;
        bus.load_minutes = '0;
        bus.load_seconds = '0;

        // Reset state, both display modes
        step();
        step();
        chk_time("reset", 0, 0, 0);
        chk("reset.pulses", pulses(), 32'd0);
        chk("reset.disp24", 32'(bus.hours_disp), 32'd0);
        chk("reset.pm", 32'(bus.pm), 32'd0);
        bus.mode_12h = 1'b1;
        #1;
        chk("reset.disp12", 32'(bus.hours_disp), 32'd12);
        bus.mode_12h = 1'b0;

        // Free run 40 cycles: a sec_pulse every 4th cycle only
        reset = 1'b0;
        bus.run = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            chk("run.pulses", pulses(), (i % 4 == 0) ? 32'd1 : 32'd0);
        end
        chk_time("run40", 0, 0, 10);

        // Day rollover from 23:59:58
        load_time(23, 59, 58);
        chk_time("load", 23, 59, 58);
        chk("load.pulses", pulses(), 32'd0);
        repeat (4) step();
        chk_time("t59", 23, 59, 59);
        chk("t59.pulses", pulses(), 32'd1);
        repeat (4) step();
        chk_time("rollover", 0, 0, 0);
        chk("rollover.pulses", pulses(), 32'hF);
        step();
        chk("after.pulses", pulses(), 32'd0);
        bus.run = 1'b0;

        // Manual set wraps without carry or pulses
        load_time(5, 59, 0);
        bus.set_min = 1'b1;
        step();
        bus.set_min = 1'b0;
        chk_time("setmin", 5, 0, 0);
        chk("setmin.pulses", pulses(), 32'd0);
        load_time(23, 10, 0);
        bus.set_hour = 1'b1;
        step();
        bus.set_hour = 1'b0;
        chk_time("sethour", 0, 10, 0);
        chk("sethour.pulses", pulses(), 32'd0);

        // set_min coincident with a carrying tick: +1 only, no min_pulse
        bus.run = 1'b1;
        load_time(12, 34, 59);
        repeat (3) step();
        chk_time("pre.tick", 12, 34, 59);
        bus.set_min = 1'b1;
        step();
        bus.set_min = 1'b0;
        chk_time("setmin.tick", 12, 35, 0);
        chk("setmin.tick.pulses", pulses(), 32'd1);

        // Run low freezes prescaler phase
        repeat (2) step();
        bus.run = 1'b0;
        repeat (5) step();
        chk("freeze.s", 32'(bus.seconds), 32'd0);
        chk("freeze.pulses", pulses(), 32'd0);
        bus.run = 1'b1;
        step();
        chk("resume1.pulses", pulses(), 32'd0);
        step();
        chk("resume2.pulses", pulses(), 32'd1);
        chk("resume2.s", 32'(bus.seconds), 32'd1);
        bus.run = 1'b0;

        // 12h display sweep
        bus.mode_12h = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_time(int'(hr_tab[i]), 0, 0);
            chk("disp12", 32'(bus.hours_disp), disp_tab[i]);
            chk("pm", 32'(bus.pm), pm_tab[i]);
        end
        bus.mode_12h = 1'b0;
        #1;
        chk("disp24", 32'(bus.hours_disp), 32'd23);

        // Out-of-range load falls back to zero
        load_time(60, 70, 99);
        chk_time("oor", 0, 0, 0);
        load_time(24, 60, 60);
        chk_time("oor.edge", 0, 0, 0);

        // Reset at terminal prescaler count: zeros, no pulse, full period after release
        bus.run = 1'b1;
        load_time(1, 2, 3);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_time("midreset", 0, 0, 0);
        chk("midreset.pulses", pulses(), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("postreset.pulses", pulses(), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("postreset.s", 32'(bus.seconds), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_counter.md
# time_counter

Parametrised time-of-day counter for the alarm clock. It replaces separate externally-clocked minute and hour counters with one synchronous block. It keeps seconds, minutes and hours from an internal clock-cycle prescaler, and supports manual set and parallel load. It gives 24-hour values and 12-hour display values, plus one-cycle rollover pulses that feed the alarm comparator and display logic.

## Interface
Parameters:
- CLK_PER_SEC, 100_000_000 — clk cycles per second; must be ≥ 2.
- CNT_W, 6 — width of every time field; must be ≥ 6.

Ports:
- clk  in  1  — single system clock; all state changes on its rising edge.
- reset  in  1  — synchronous, active-high; clears all state.
- run  in  1  — when high, the prescaler advances and time counts.
- mode_12h  in  1  — selects the encoding of hours_disp.
- set_min  in  1  — one-cycle pulse; increments minutes by 1 and wraps 59→0, with no carry into hours.
- set_hour  in  1  — one-cycle pulse; increments hours by 1 and wraps 23→0.
- load  in  1  — one-cycle pulse; parallel-loads the three load_* fields.
- load_hours, load_minutes, load_seconds  in  CNT_W each  — values captured on load.
- seconds, minutes  out  CNT_W  — 0..59.
- hours  out  CNT_W  — 0..23, always 24-hour.
- hours_disp  out  CNT_W  — equals hours when mode_12h=0; 1..12 when mode_12h=1.
- pm  out  1  — 1 when hours ≥ 12.
- sec_pulse, min_pulse, hour_pulse, day_pulse  out  1  — one-cycle carry pulses.

## Operation
- Prescaler: counts 0..CLK_PER_SEC-1 while run=1 and holds while run=0.
  - At terminal count it returns to 0 and generates an internal tick.
- On tick:
  - seconds increments; 59→0 carries into minutes.
  - minutes 59→0 carries into hours.
  - hours 23→0 is a day rollover.
- Priority per cycle: reset > load > set_min/set_hour > tick.
- load:
  - Writes all three fields and clears the prescaler.
  - Any out-of-range field (seconds/minutes > 59, hours > 23) loads as 0.
  - No pulses are generated.
- set_min / set_hour:
  - Each pulse is exactly +1 on its field. Both may be asserted in the same cycle.
  - A tick in the same cycle still updates seconds.
  - A carry from that tick into a field being set is dropped: set gives +1, never +2.
  - Manual set never generates min_pulse, hour_pulse or day_pulse.
- hours_disp when mode_12h=1: 0→12, 1..12 unchanged, 13..23 → hours-12. Combinational from hours and mode_12h.
- pm: combinational from hours.

## Timing
- Reset value: seconds, minutes, hours, prescaler and all pulses are 0.
  - Consequently hours_disp is 0 in 24h mode or 12 in 12h mode, and pm is 0.
- Reset asserted mid-count clears everything on the next edge, with no pulse output. Counting resumes from 0 the first cycle after reset is released, if run=1.
- seconds/minutes/hours are registered and update on the edge after the terminal prescaler count.
- Pulses are registered and high for exactly one cycle, coincident with the first cycle in which the updated value is visible:
  - sec_pulse on every tick;
  - min_pulse when seconds wraps;
  - hour_pulse when minutes wraps via carry;
  - day_pulse when hours wraps via carry.
- At 23:59:59 a tick makes all four pulses high in the same cycle, and the value reads 00:00:00.
- Tick period is exactly CLK_PER_SEC cycles while run stays high.
  - Lowering run freezes the prescaler phase.
  - Raising run resumes from that phase.
- set/load effects are visible one cycle after the pulse.

## Structure
- Shared package time_pkg holds SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, HOUR_12=12, and the default CNT_W.
- One sub-module, mod_counter, parameters MAX and W. Its function:
  - inputs: clk, reset, inc, load, load_val;
  - output value, plus combinational wrap (inc && value==MAX);
  - out-of-range load_val is loaded as 0.
  - It is instantiated three times.
- The top level handles the prescaler, carry gating, priority, pulse registers and 12h conversion.

## Test plan
- Reset, then run=1 with CLK_PER_SEC=4 for 40 cycles → seconds=10, one sec_pulse every 4 cycles, no other pulses.
- load 23:59:58, run 8 cycles → at 23:59:59 only sec_pulse fires; next tick gives 00:00:00 with sec/min/hour/day pulses all high for one cycle.
- set_min at minutes=59, hours=5 → minutes=0, hours=5, no pulses; set_hour at 23 → 0, no day_pulse.
- set_min in the same cycle as a tick carrying 12:34:59 → seconds=0, minutes=35 (not 36), min_pulse=0.
- mode_12h=1 sweep of hours 0, 1, 12, 13, 23 → hours_disp 12, 1, 12, 1, 11; pm 0, 0, 1, 1, 1.
- load 60:70:99 → 00:00:00; reset pulsed mid-prescaler during run → all zeros next cycle, first sec_pulse CLK_PER_SEC cycles after reset release.
